// File: rtl/axi_wr_guard_arbiter.sv
// Two-master AXI4 write arbiter with WLAST regeneration, oversize rejection, stall padding and violation tracking.
// Define AXI_GUARD_QUARANTINE_EN to quarantine masters that hit ERR_LIMIT violations.

module axi_wr_guard_tracker #(
  parameter int ERR_LIMIT    = 4,
  parameter int BLOCK_CYCLES = 4096
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       viol_i,
  output logic [3:0] cnt_o,
  output logic       blocked_o
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (viol_i && cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
  end

  assign cnt_o = cnt_q;

`ifdef AXI_GUARD_QUARANTINE_EN
  logic [15:0] blk_q;
  logic        blocked_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt_q     <= '0;
      blk_q     <= '0;
      blocked_q <= 1'b0;
    end else if (viol_i && cnt_d == ERR_LIMIT[3:0]) begin
      cnt_q     <= '0;
      blk_q     <= BLOCK_CYCLES[15:0];
      blocked_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (blocked_q) begin
        blk_q <= blk_q - 16'd1;
        if (blk_q == 16'd1) blocked_q <= 1'b0;
      end
    end
  end

  assign blocked_o = blocked_q;
`else
  logic unused_cfg;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign unused_cfg = ^{ERR_LIMIT, BLOCK_CYCLES};
  assign blocked_o  = 1'b0;
`endif
endmodule

module axi_wr_guard_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ID_W         = 4,
  parameter int MAX_LEN      = 15,
  parameter int STALL_LIMIT  = 64,
  parameter int ERR_LIMIT    = 4,
  parameter int BLOCK_CYCLES = 4096
) (
  input  logic                clk_100MHz,
  input  logic                reset_rtl_0,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [ID_W-1:0]     s0_awid,
  input  logic [7:0]          s0_awlen,
  input  logic [2:0]          s0_awsize,
  input  logic [1:0]          s0_awburst,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wlast,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  output logic [1:0]          s0_bresp,
  output logic [ID_W-1:0]     s0_bid,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [ID_W-1:0]     s1_awid,
  input  logic [7:0]          s1_awlen,
  input  logic [2:0]          s1_awsize,
  input  logic [1:0]          s1_awburst,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wlast,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  output logic [1:0]          s1_bresp,
  output logic [ID_W-1:0]     s1_bid,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [ID_W-1:0]     m_awid,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  input  logic [ID_W-1:0]     m_bid,
  output logic [3:0]          viol_cnt0,
  output logic [3:0]          viol_cnt1,
  output logic [1:0]          blocked,
  output logic                viol_irq
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, PAD, RESP, SINK, ERRB} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } aw_t;

  typedef struct packed {
    logic                valid;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
  } w_t;

  state_e          state_q, state_d;
  logic            owner_q, owner_d, rr_q, rr_d, err_q, err_d, sink_aw_q, sink_aw_d;
  logic [7:0]      len_q, len_d, beat_q, beat_d;
  logic [15:0]     stall_q, stall_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            irq_q, viol, viol_m;
  logic [1:0]      elig, viol_vec;
  logic [1:0][3:0] cnt_vec;
  logic            own_awready, own_wready, own_bvalid, own_bready;
  logic [1:0]      own_bresp;
  aw_t  [1:0]      s_aw;
  w_t   [1:0]      s_w;
  aw_t             aw_own;
  w_t              w_own;
  logic            unused_bid;

  assign s_aw[0] = {s0_awaddr, s0_awid, s0_awlen, s0_awsize, s0_awburst};
  assign s_aw[1] = {s1_awaddr, s1_awid, s1_awlen, s1_awsize, s1_awburst};
  assign s_w[0]  = {s0_wvalid, s0_wdata, s0_wstrb, s0_wlast};
  assign s_w[1]  = {s1_wvalid, s1_wdata, s1_wstrb, s1_wlast};
  assign aw_own  = s_aw[owner_q];
  assign w_own   = s_w[owner_q];
  assign own_bready = owner_q ? s1_bready : s0_bready;
  assign elig    = {s1_awvalid & ~blocked[1], s0_awvalid & ~blocked[0]};

  assign {m_awaddr, m_awid, m_awlen, m_awsize, m_awburst} = aw_own;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    err_d       = err_q;
    sink_aw_d   = sink_aw_q;
    len_d       = len_q;
    beat_d      = beat_q;
    stall_d     = stall_q;
    id_d        = id_q;
    viol        = 1'b0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_wdata     = w_own.data;
    m_wstrb     = w_own.strb;
    m_wlast     = 1'b0;
    m_bready    = 1'b0;
    own_awready = 1'b0;
    own_wready  = 1'b0;
    own_bvalid  = 1'b0;
    own_bresp   = m_bresp;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          owner_d   = (&elig) ? rr_q : elig[1];
          len_d     = s_aw[owner_d].len;
          id_d      = s_aw[owner_d].id;
          beat_d    = '0;
          stall_d   = '0;
          sink_aw_d = 1'b0;
          err_d     = 1'b0;
          if (int'(len_d) > MAX_LEN) begin
            viol    = 1'b1;
            err_d   = 1'b1;
            state_d = SINK;
          end else begin
            state_d = ADDR;
          end
        end
      end
      ADDR: begin
        m_awvalid   = 1'b1;
        own_awready = m_awready;
        if (m_awready) state_d = DATA;
      end
      DATA: begin
        m_wvalid   = w_own.valid;
        own_wready = m_wready;
        m_wlast    = (beat_q == len_q);
        if (w_own.valid) begin
          if (m_wready) begin
            stall_d = '0;
            beat_d  = beat_q + 8'd1;
            // downstream WLAST is always ours; a disagreeing master still completes the burst
            if (w_own.last != m_wlast && !err_q) begin
              viol  = 1'b1;
              err_d = 1'b1;
            end
            if (m_wlast) state_d = RESP;
          end
        end else if (stall_q == 16'(STALL_LIMIT - 1)) begin
          viol    = !err_q;
          err_d   = 1'b1;
          state_d = PAD;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      PAD: begin
        m_wvalid = 1'b1;
        m_wdata  = '0;
        m_wstrb  = '0;
        m_wlast  = (beat_q == len_q);
        if (m_wready) begin
          beat_d = beat_q + 8'd1;
          if (m_wlast) state_d = RESP;
        end
      end
      RESP: begin
        m_bready   = own_bready;
        own_bvalid = m_bvalid;
        own_bresp  = err_q ? 2'b10 : m_bresp;
        if (m_bvalid && own_bready) begin
          state_d = IDLE;
          rr_d    = ~owner_q;
        end
      end
      SINK: begin
        if (!sink_aw_q) begin
          own_awready = 1'b1;
          sink_aw_d   = 1'b1;
        end else begin
          own_wready = 1'b1;
          if (w_own.valid) begin
            stall_d = '0;
            beat_d  = beat_q + 8'd1;
            if (beat_q == len_q) state_d = ERRB;
          end else if (stall_q == 16'(STALL_LIMIT - 1)) begin
            state_d = ERRB;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      ERRB: begin
        own_bvalid = 1'b1;
        own_bresp  = 2'b10;
        if (own_bready) begin
          state_d = IDLE;
          rr_d    = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      err_q     <= 1'b0;
      sink_aw_q <= 1'b0;
      len_q     <= '0;
      beat_q    <= '0;
      stall_q   <= '0;
      id_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      err_q     <= err_d;
      sink_aw_q <= sink_aw_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      stall_q   <= stall_d;
      id_q      <= id_d;
      irq_q     <= viol;
    end
  end

  // in IDLE the offender is the master being granted this cycle
  assign viol_m   = (state_q == IDLE) ? owner_d : owner_q;
  assign viol_vec = viol ? (viol_m ? 2'b10 : 2'b01) : 2'b00;

  axi_wr_guard_tracker #(.ERR_LIMIT(ERR_LIMIT), .BLOCK_CYCLES(BLOCK_CYCLES)) u_trk [1:0] (
    .gclk      (clk_100MHz),
    .grst_n    (reset_rtl_0),
    .viol_i    (viol_vec),
    .cnt_o     (cnt_vec),
    .blocked_o (blocked)
  );

  assign viol_cnt0  = cnt_vec[0];
  assign viol_cnt1  = cnt_vec[1];
  assign viol_irq   = irq_q;

  assign s0_awready = own_awready & ~owner_q;
  assign s1_awready = own_awready &  owner_q;
  assign s0_wready  = own_wready  & ~owner_q;
  assign s1_wready  = own_wready  &  owner_q;
  assign s0_bvalid  = own_bvalid  & ~owner_q;
  assign s1_bvalid  = own_bvalid  &  owner_q;
  assign s0_bresp   = own_bresp;
  assign s1_bresp   = own_bresp;
  assign s0_bid     = id_q;
  assign s1_bid     = id_q;
  assign unused_bid = ^m_bid;
endmodule

// File: tb/tb_axi_wr_guard_arbiter.sv
// Scoreboard bench for axi_wr_guard_arbiter: expected AW/W/B traffic is queued up front and
// popped by negedge monitors on each handshake. Build with AXI_GUARD_QUARANTINE_EN for the quarantine case.

module tb_axi_wr_guard_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_awvalid, s0_awready, s1_awvalid, s1_awready;
  logic [31:0] s0_awaddr, s1_awaddr;
  logic [3:0]  s0_awid, s1_awid;
  logic [7:0]  s0_awlen, s1_awlen;
  logic [2:0]  s0_awsize, s1_awsize;
  logic [1:0]  s0_awburst, s1_awburst;
  logic        s0_wvalid, s0_wready, s0_wlast, s1_wvalid, s1_wready, s1_wlast;
  logic [31:0] s0_wdata, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_bvalid, s0_bready, s1_bvalid, s1_bready;
  logic [1:0]  s0_bresp, s1_bresp;
  logic [3:0]  s0_bid, s1_bid;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_awid, m_wstrb, m_bid;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_bresp;
  logic [3:0]  viol_cnt0, viol_cnt1;
  logic [1:0]  blocked;
  logic        viol_irq;

  int nchk = 0, nfail = 0, irq_cnt = 0, exp_irq = 0, pend_b = 0;
  logic [43:0] exp_aw[$];
  logic [36:0] exp_w[$];
  logic [5:0]  exp_b0[$], exp_b1[$];
  logic [43:0] e_aw;
  logic [36:0] e_w;
  logic [5:0]  e_b0, e_b1;

  always #5 clk = ~clk;

  axi_wr_guard_arbiter dut (
    .clk_100MHz(clk), .reset_rtl_0(rst_n),
    .s0_awvalid(s0_awvalid), .s0_awready(s0_awready), .s0_awaddr(s0_awaddr), .s0_awid(s0_awid),
    .s0_awlen(s0_awlen), .s0_awsize(s0_awsize), .s0_awburst(s0_awburst),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_bresp(s0_bresp), .s0_bid(s0_bid),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready), .s1_awaddr(s1_awaddr), .s1_awid(s1_awid),
    .s1_awlen(s1_awlen), .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_bresp(s1_bresp), .s1_bid(s1_bid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
    .viol_cnt0(viol_cnt0), .viol_cnt1(viol_cnt1), .blocked(blocked), .viol_irq(viol_irq)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    nchk++;
    nfail++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  // monitors: pop the expected item whenever a handshake is on the bus
  always @(negedge clk) if (rst_n) begin
    if (m_awvalid && m_awready) begin
      if (exp_aw.size() == 0) chk("m_aw_unexpected", 64'(exp_aw.size()), 64'd1);
      else begin e_aw = exp_aw.pop_front(); chk("m_aw", {m_awaddr, m_awid, m_awlen}, 64'(e_aw)); end
    end
    if (m_wvalid && m_wready) begin
      if (exp_w.size() == 0) chk("m_w_unexpected", 64'(exp_w.size()), 64'd1);
      else begin e_w = exp_w.pop_front(); chk("m_w", {m_wdata, m_wstrb, m_wlast}, 64'(e_w)); end
    end
    if (s0_bvalid && s0_bready) begin
      if (exp_b0.size() == 0) chk("s0_b_unexpected", 64'(exp_b0.size()), 64'd1);
      else begin e_b0 = exp_b0.pop_front(); chk("s0_b", {s0_bresp, s0_bid}, 64'(e_b0)); end
    end
    if (s1_bvalid && s1_bready) begin
      if (exp_b1.size() == 0) chk("s1_b_unexpected", 64'(exp_b1.size()), 64'd1);
      else begin e_b1 = exp_b1.pop_front(); chk("s1_b", {s1_bresp, s1_bid}, 64'(e_b1)); end
    end
    if (viol_irq) irq_cnt++;
  end

  // downstream slave: always ready, one OKAY response per completed burst
  initial begin
    int whs, bhs;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = 4'h0;
    forever begin
      @(negedge clk);
      whs = int'(m_wvalid && m_wready && m_wlast);
      bhs = int'(m_bvalid && m_bready);
      @(posedge clk); #1;
      if (!rst_n) pend_b = 0;
      else        pend_b = pend_b + whs - bhs;
      m_bvalid = (pend_b > 0);
    end
  end

  task automatic set_aw(input int m, input logic v, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    if (m == 0) begin s0_awvalid = v; s0_awaddr = a; s0_awid = id; s0_awlen = len; end
    else        begin s1_awvalid = v; s1_awaddr = a; s1_awid = id; s1_awlen = len; end
  endtask

  task automatic set_w(input int m, input logic v, input logic [31:0] d, input logic l);
    if (m == 0) begin s0_wvalid = v; s0_wdata = d; s0_wlast = l; end
    else        begin s1_wvalid = v; s1_wdata = d; s1_wlast = l; end
  endtask

  task automatic set_b(input int m, input logic v);
    if (m == 0) s0_bready = v;
    else        s1_bready = v;
  endtask

  function automatic logic awrdy(input int m); return (m == 0) ? s0_awready : s1_awready; endfunction
  function automatic logic wrdy(input int m);  return (m == 0) ? s0_wready  : s1_wready;  endfunction
  function automatic logic bvld(input int m);  return (m == 0) ? s0_bvalid  : s1_bvalid;  endfunction

  // bad: beat whose WLAST is inverted; stop: first beat not sent (burst then stalls)
  task automatic do_write(input int m, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [31:0] d0, input int bad, input int stop, input bit nolast);
    int t;
    logic lst;
    set_aw(m, 1'b1, addr, id, len);
    t = 0;
    do begin @(negedge clk); t++; end while (!awrdy(m) && t < 1000);
    if (!awrdy(m)) begin tmo("aw_wait"); set_aw(m, 1'b0, 0, 0, 0); return; end
    @(posedge clk); #1;
    set_aw(m, 1'b0, 0, 0, 0);
    for (int b = 0; b <= int'(len); b++) begin
      if (b == stop) break;
      lst = nolast ? 1'b0 : (b == int'(len));
      if (b == bad) lst = ~lst;
      set_w(m, 1'b1, d0 + 32'(b), lst);
      t = 0;
      do begin @(negedge clk); t++; end while (!wrdy(m) && t < 1000);
      if (!wrdy(m)) begin tmo("w_wait"); set_w(m, 1'b0, 0, 1'b0); return; end
      @(posedge clk); #1;
    end
    set_w(m, 1'b0, 0, 1'b0);
    set_b(m, 1'b1);
    t = 0;
    do begin @(negedge clk); t++; end while (!bvld(m) && t < 1000);
    if (!bvld(m)) tmo("b_wait");
    @(posedge clk); #1;
    set_b(m, 1'b0);
  endtask

  task automatic push_b(input int m, input logic [1:0] r, input logic [3:0] id);
    if (m == 0) exp_b0.push_back({r, id});
    else        exp_b1.push_back({r, id});
  endtask

  task automatic push_txn(input int m, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [31:0] d0, input logic [1:0] r);
    exp_aw.push_back({a, id, len});
    for (int b = 0; b <= int'(len); b++) exp_w.push_back({d0 + 32'(b), 4'hF, b == int'(len)});
    push_b(m, r, id);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_aw(0, 1'b0, 0, 0, 0); set_aw(1, 1'b0, 0, 0, 0);
    set_w(0, 1'b0, 0, 1'b0);  set_w(1, 1'b0, 0, 1'b0);
    set_b(0, 1'b0);           set_b(1, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    s0_wstrb = 4'hF; s1_wstrb = 4'hF;
    s0_awsize = 3'd2; s1_awsize = 3'd2; s0_awburst = 2'b01; s1_awburst = 2'b01;
    rst_n = 1'b0;
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_m_wvalid",  m_wvalid, 0);
    chk("rst_m_bready",  m_bready, 0);
    chk("rst_s_readies", {s0_awready, s1_awready, s0_wready, s1_wready, s0_bvalid, s1_bvalid}, 0);
    chk("rst_viol_cnt",  {viol_cnt1, viol_cnt0}, 0);
    chk("rst_blocked",   blocked, 0);
    chk("rst_viol_irq",  viol_irq, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single OKAY write
    push_txn(0, 32'h4000_0004, 4'h1, 8'd0, 32'hCAFE_0001, 2'b00);
    do_write(0, 32'h4000_0004, 4'h1, 8'd0, 32'hCAFE_0001, -1, -1, 1'b0);

    // simultaneous requests after reset: s0, s1, then s0 wins the next tie
    do_reset();
    push_txn(0, 32'h4000_0100, 4'h2, 8'd1, 32'h1111_0000, 2'b00);
    push_txn(1, 32'h4000_0200, 4'h3, 8'd2, 32'h2222_0000, 2'b00);
    fork
      do_write(0, 32'h4000_0100, 4'h2, 8'd1, 32'h1111_0000, -1, -1, 1'b0);
      do_write(1, 32'h4000_0200, 4'h3, 8'd2, 32'h2222_0000, -1, -1, 1'b0);
    join
    push_txn(0, 32'h4000_0300, 4'h4, 8'd0, 32'h3333_0000, 2'b00);
    push_txn(1, 32'h4000_0400, 4'h5, 8'd1, 32'h4444_0000, 2'b00);
    fork
      do_write(0, 32'h4000_0300, 4'h4, 8'd0, 32'h3333_0000, -1, -1, 1'b0);
      do_write(1, 32'h4000_0400, 4'h5, 8'd1, 32'h4444_0000, -1, -1, 1'b0);
    join
    chk("viol_clean", {viol_cnt1, viol_cnt0}, 0);

    // oversized burst is sunk, nothing forwarded
    push_b(1, 2'b10, 4'h6);
    exp_irq++;
    do_write(1, 32'h4000_0500, 4'h6, 8'd255, 32'h5555_0000, -1, -1, 1'b1);
    chk("sink_viol_cnt1", viol_cnt1, 1);
    chk("sink_viol_cnt0", viol_cnt0, 0);
    push_txn(0, 32'h4000_0600, 4'h7, 8'd0, 32'h6666_0000, 2'b00);
    do_write(0, 32'h4000_0600, 4'h7, 8'd0, 32'h6666_0000, -1, -1, 1'b0);

    // master WLAST missing on final beat: downstream WLAST still correct
    push_txn(0, 32'h4000_0700, 4'h8, 8'd3, 32'h7777_0000, 2'b10);
    exp_irq++;
    do_write(0, 32'h4000_0700, 4'h8, 8'd3, 32'h7777_0000, 3, -1, 1'b0);
    chk("wlast_viol_cnt0", viol_cnt0, 1);
    chk("irq_after_wlast", irq_cnt, exp_irq);

    // stalled burst is padded with zero-strobe beats
    exp_aw.push_back({32'h4000_0800, 4'h9, 8'd3});
    exp_w.push_back({32'h8888_0000, 4'hF, 1'b0});
    exp_w.push_back({32'h8888_0001, 4'hF, 1'b0});
    exp_w.push_back({32'h0, 4'h0, 1'b0});
    exp_w.push_back({32'h0, 4'h0, 1'b1});
    push_b(0, 2'b10, 4'h9);
    exp_irq++;
    do_write(0, 32'h4000_0800, 4'h9, 8'd3, 32'h8888_0000, -1, 2, 1'b0);
    chk("stall_viol_cnt0", viol_cnt0, 2);
    chk("irq_after_stall", irq_cnt, exp_irq);

`ifdef AXI_GUARD_QUARANTINE_EN
    for (int k = 0; k < 3; k++) begin
      push_txn(1, 32'h4000_0900 + 32'(k * 16), 4'hA, 8'd0, 32'h9999_0000 + 32'(k * 16), 2'b10);
      exp_irq++;
      do_write(1, 32'h4000_0900 + 32'(k * 16), 4'hA, 8'd0, 32'h9999_0000 + 32'(k * 16), 0, -1, 1'b0);
    end
    chk("q_blocked", blocked, 2'b10);
    chk("q_cnt1_cleared", viol_cnt1, 0);
    set_aw(1, 1'b1, 32'h4000_0A00, 4'hB, 8'd0);
    push_txn(0, 32'h4000_0B00, 4'hC, 8'd0, 32'hAAAA_0000, 2'b00);
    do_write(0, 32'h4000_0B00, 4'hC, 8'd0, 32'hAAAA_0000, -1, -1, 1'b0);
    n = 0;
    repeat (40) begin @(negedge clk); if (s1_awready || m_awvalid) n++; end
    chk("q_s1_ignored", n, 0);
    chk("q_still_blocked", blocked, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("q_rst_clears", blocked, 0);
    do_reset();
`else
    chk("blocked_tied", blocked, 0);
`endif

    repeat (3) @(negedge clk);
    chk("irq_pulses", irq_cnt, exp_irq);
    chk("aw_q_drained", exp_aw.size(), 0);
    chk("w_q_drained",  exp_w.size(), 0);
    chk("b_q_drained",  exp_b0.size() + exp_b1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/axi_wr_guard_arbiter.md
# axi_wr_guard_arbiter

Two-master AXI4 write-channel arbiter with bus-monopoly protection, placed between the victim/attacker AXI masters and the BRAM-side interconnect slave port. Grants one write burst at a time round-robin, generates downstream WLAST from AWLEN itself, rejects oversized bursts, pads stalled bursts, and reports or quarantines misbehaving masters. Read channels are out of scope.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (STRB = DATA_W/8)
- ID_W, 4, AWID width
- MAX_LEN, 15, largest accepted AWLEN; larger is rejected
- STALL_LIMIT, 64, idle W cycles before padding (16-bit counter)
- ERR_LIMIT, 4, violations before quarantine (4-bit counter)
- BLOCK_CYCLES, 4096, quarantine duration (16-bit counter)

- clk_100MHz  in  1  clock
- reset_rtl_0  in  1  asynchronous, active-low reset
- s{0,1}_awvalid/awready  in/out  1  master AW handshake
- s{0,1}_awaddr/awid/awlen/awsize/awburst  in  ADDR_W/ID_W/8/3/2  master AW payload
- s{0,1}_wvalid/wready  in/out  1  master W handshake
- s{0,1}_wdata/wstrb/wlast  in  DATA_W/STRB/1  master W payload
- s{0,1}_bvalid/bready  out/in  1  master B handshake
- s{0,1}_bresp/bid  out  2/ID_W  master B payload
- m_aw*, m_w*, m_b*  mirror  same widths  single downstream port (m_wlast generated)
- viol_cnt0, viol_cnt1  out  4  saturating violation counters
- blocked  out  2  per-master quarantine flag
- viol_irq  out  1  one-cycle pulse per violation

## Operation
- FSM: IDLE, ADDR, DATA, PAD, RESP, SINK, ERRB.
- IDLE: eligible = awvalid && !blocked. Both eligible → pick rr pointer; one → that one. Latch owner, awlen, awid; next: ADDR if awlen<=MAX_LEN else SINK.
- ADDR: m_aw* = owner's AW; s_awready(owner)=m_awready. On handshake → DATA, beat=0, stall=0.
- DATA: m_wvalid/wdata/wstrb from owner, s_wready(owner)=m_wready; m_wlast = (beat==len). Each accepted beat: beat++, stall=0. Owner wlast ≠ (beat==len) on any beat → violation, err flag. Last beat accepted → RESP. s_wvalid low: stall++; stall==STALL_LIMIT → violation, err flag, PAD.
- PAD: m_wvalid=1, wdata=0, wstrb=0, s_wready(owner)=0; completes remaining beats with correct m_wlast → RESP.
- RESP: m_bready = s_bready(owner); s_bvalid(owner)=m_bvalid; bresp = err ? SLVERR(2'b10) : m_bresp; bid = latched id. Handshake → IDLE, rr = other master.
- SINK (oversized AWLEN): violation; s_awready pulsed one cycle, then s_wready=1 for awlen+1 beats (stall rule ends early); nothing forwarded → ERRB.
- ERRB: s_bvalid=1, bresp=SLVERR, bid=latched; on bready → IDLE, rr flips.
- Non-owner always sees awready=wready=bvalid=0. Downstream idle outputs: all valids 0, m_bready 0.
- viol_cnt saturates at 15.

## Timing
- Reset: FSM IDLE, rr=0, all valids/readies 0, counters 0, blocked=0, viol_irq=0. Reset mid-burst abandons the transaction; no completion emitted.
- Arbitration: 1 cycle (IDLE) from awvalid to ADDR; AW forwarded combinationally in ADDR; W/B paths combinational, zero added latency.
- Simultaneous request in IDLE: rr winner; loser waits one full transaction.
- viol_irq asserted the cycle after the violating event; one violation maximum per transaction.
- Master deasserting awvalid in ADDR is a protocol error: unsupported, no recovery.

## Configuration
- AXI_GUARD_QUARANTINE_EN defined: when viol_cnt reaches ERR_LIMIT, blocked[i]=1 for BLOCK_CYCLES cycles, viol_cnt cleared at block start; blocked master ignored in IDLE; block starting mid-transaction takes effect after RESP/ERRB.
- Undefined: blocked tied 0; counters and viol_irq still operate.

## Test plan
- Single write s0, awlen=0, data 0xCAFE0001 → m_awaddr=0x40000004, one beat with m_wlast=1, s0_bresp=OKAY.
- Both masters awvalid same cycle after reset → s0 served first, then s1; next tie goes to s0 again.
- s1 awlen=255, WVALID held, WLAST=0 → SINK 256 beats, s1_bresp=SLVERR, viol_cnt1=1, nothing on m_aw; s0 write then completes OKAY.
- s0 awlen=3, wlast=0 on beat 3 → m_wlast=1 on beat 3, s0_bresp=SLVERR, viol_irq pulse.
- s0 awlen=3, stops after beat 1 → after 64 cycles two padded beats wstrb=0, SLVERR.
- With AXI_GUARD_QUARANTINE_EN, four s1 violations → blocked[1]=1 for 4096 cycles, s0 sole grantee; reset mid-block clears blocked.
